// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of NCH glitch-free programmable clock dividers
//
// Purpose: NCH independent 50%-duty clock dividers clocked from clkin, each
// with a one-cycle tick on the rising edge of its divided clock and a
// run-time divisor that is only swapped in at a half-period boundary.
//
// Ports:
//   clkin    in   1     system clock, all logic on posedge
//   rst      in   1     synchronous active-high reset
//   align    in   1     (only with CLKDIV_PHASE_ALIGN_EN) restart all enabled channels
//   en       in   NCH   per-channel run enable
//   cfg_wr   in   1     strobe: write cfg_div as pending divisor of channel cfg_ch
//   cfg_ch   in   CHW   target channel; values >= NCH are ignored
//   cfg_div  in   CW    new half-period divisor
//   clkout   out  NCH   divided clocks, period 2*(div+1)
//   tick     out  NCH   one-cycle pulse when clkout[i] rises
//   pend     out  NCH   a written divisor is waiting to take effect
//
// Optional feature macro: CLKDIV_PHASE_ALIGN_EN (adds the align input).

module clock_divider_bank #(
  parameter int NCH     = 4,
  parameter int CW      = 26,
  parameter int DEF_DIV = 50,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clkin,
  input  logic           rst,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic           align,
`endif
  input  logic [NCH-1:0] en,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  logic [CW-1:0]  count_q    [NCH];
  logic [CW-1:0]  count_d    [NCH];
  logic [CW-1:0]  div_q      [NCH];
  logic [CW-1:0]  div_d      [NCH];
  logic [CW-1:0]  pend_div_q [NCH];
  logic [CW-1:0]  pend_div_d [NCH];
  logic [NCH-1:0] clkout_q, clkout_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic           align_w;

`ifdef CLKDIV_PHASE_ALIGN_EN
  assign align_w = align;
`else
  assign align_w = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      logic apply;
      logic wr_hit;
      count_d[i]    = count_q[i];
      div_d[i]      = div_q[i];
      pend_div_d[i] = pend_div_q[i];
      clkout_d[i]   = clkout_q[i];
      tick_d[i]     = 1'b0;
      pend_d[i]     = pend_q[i];
      apply         = 1'b0;
      // Channel indices never exceed NCH-1, so an out-of-range cfg_ch
      // simply matches no channel.
      wr_hit        = cfg_wr && (cfg_ch == CHW'(i));

      if (!en[i] || align_w) begin
        // Idle or forced restart: park low at count 0, free to take a new divisor.
        count_d[i]  = '0;
        clkout_d[i] = 1'b0;
        apply       = 1'b1;
      end else if (count_q[i] == div_q[i]) begin
        // Half-period boundary: the only point a running channel may swap
        // divisors, which keeps every half-period whole.
        count_d[i]  = '0;
        clkout_d[i] = ~clkout_q[i];
        tick_d[i]   = ~clkout_q[i];
        apply       = 1'b1;
      end else begin
        count_d[i]  = count_q[i] + CW'(1);
      end

      if (apply && pend_q[i]) begin
        div_d[i]  = pend_div_q[i];
        pend_d[i] = 1'b0;
      end

      // A write in the same cycle as an apply queues behind it.
      if (wr_hit) begin
        pend_div_d[i] = cfg_div;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        count_q[i]    <= '0;
        div_q[i]      <= CW'(DEF_DIV);
        pend_div_q[i] <= CW'(DEF_DIV);
      end
      clkout_q <= '0;
      tick_q   <= '0;
      pend_q   <= '0;
    end else begin
      count_q    <= count_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
      pend_q     <= pend_d;
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;
  assign pend   = pend_q;

endmodule
